i2si_deserializer: RTL and testbench
====================================

Name: i2si_deserializer

Overview:
- Receives a serial I2S-style audio stream (bit clock, word select, data) from an off-chip source and converts it into parallel 16-bit left/right sample words in the `clk` domain.
- Sits between the I2S input pads and the audio datapath.
- `rf_i2si_en` is a register-file enable.
- Presents each stereo pair together, marked by a single-cycle transfer strobe.

Parameters:
- DW, 16, sample word width per channel (bits).
- SYNC_STAGES, 2, flops in each input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock; everything is sampled in this domain.
- rst  in  1  asynchronous active-low reset.
- i2si_sck  in  1  serial bit clock, asynchronous to clk. Each high and low phase is at least 4 clk periods.
- i2si_ws  in  1  word select: 0 = left channel, 1 = right channel. Changes on sck falling edges.
- i2si_sd  in  1  serial data, MSB first. Changes on sck falling edges.
- rf_i2si_en  in  1  block enable (register-file bit).
- i2si_lft  out  DW  last complete left sample.
- i2si_rgt  out  DW  last complete right sample.
- i2si_xfc  out  1  one-clk pulse: a new left/right pair is valid on i2si_lft/i2si_rgt.

Behaviour:
- Reset (rst=0, async): i2si_lft=0, i2si_rgt=0, i2si_xfc=0. Shift register, bit counter, staged left word and aligned flag are cleared. Previous-ws register is set to 1.
- sck, ws and sd each pass through a SYNC_STAGES flop synchronizer.
- An sck rising edge is detected as (synced sck=1, delayed synced sck=0). All sampling happens only on that one-clk event; sck falling edges are ignored.
- On each sampled rising edge:
  - If ws differs from the previous ws sample: start a new channel word. Counter=0, shift register loads sd, aligned=1. This is left-justified framing: the MSB arrives in the first bit period after the ws change.
  - Otherwise, if aligned and counter<DW-1: shift sd in at the LSB and increment the counter.
  - Bits beyond DW within one ws phase are ignored.
  - Update the previous-ws register.
- Word completion is when the DW-th bit of a channel is captured:
  - ws=0 (left): the word goes into the staged-left register. Outputs do not change.
  - ws=1 (right): on the next clk, i2si_lft gets the staged-left word and i2si_rgt gets the right word simultaneously, and i2si_xfc=1 for exactly one clk.
- Short word (ws toggles before DW bits): the partial word is discarded, there is no capture, and the new channel starts.
- A right word with no staged left since the last xfc is still output; i2si_lft repeats the previous staged value.
- Latency: i2si_xfc rises SYNC_STAGES+2 clk edges after the sck rising edge carrying the right LSB. That is 4 edges at the defaults (±1 clk of synchronizer uncertainty).
- rf_i2si_en=0:
  - Counter, shift register and aligned are held cleared.
  - No captures, i2si_xfc=0.
  - i2si_lft/i2si_rgt hold their values.
  - The previous-ws register keeps tracking ws.
- rf_i2si_en 0→1 mid-frame: nothing is captured until the next ws transition (aligned=0).
- Reset mid-word: all partial data is lost and alignment must be reacquired.

Optional Feature:
- Macro I2SI_PHILIPS_DELAY_EN.
- When defined: standard Philips I2S framing. The first sampled rising edge after a ws change is a dummy bit and is dropped; the MSB is taken on the following edge. Everything else is unchanged.
- When undefined: left-justified framing as described above.

Decomposition:
- Package i2si_pkg holds:
  - DW default (16).
  - Channel constants CH_LEFT=1'b0, CH_RIGHT=1'b1.
  - SYNC_STAGES default.
- One natural sub-module: i2si_sync, a parameterized N-flop synchronizer with async active-low reset. It is instantiated three times (sck, ws, sd).
- Edge detection, shifting and the output registers stay in the top module.

Test Plan:
- Reset and enable sequence:
  - Stimulus: rst=0, ws=1, sd=0, then rst=1.
  - Response: i2si_lft=0, i2si_rgt=0, i2si_xfc=0 throughout.
  - Stimulus: ws→0 and 16 bits of 0xAAAA, then ws→1 and 16 bits of 0x0000.
  - Response: one xfc pulse ~4 clk after the 32nd sck rise, with i2si_lft=0xAAAA, i2si_rgt=0x0000.
- Continuous frames:
  - Stimulus: L=0xFF00/R=0x1478, then L=0xA3B9/R=0xCDD7 back-to-back.
  - Response: two xfc pulses, each with the correct pair; no xfc after left words.
- Disable:
  - Stimulus: rf_i2si_en=0 during a frame of L=0x1234/R=0x5678.
  - Response: no xfc; outputs hold their prior values.
  - Stimulus: re-enable mid-left-word.
  - Response: the first xfc comes only after a full ws-aligned L/R pair.
- Short and long words:
  - Stimulus: ws toggles after 10 left bits.
  - Response: no left capture.
  - Stimulus: a 20-bit right phase carrying 0xBABA in its first 16 bits.
  - Response: i2si_rgt=0xBABA; the extra bits are ignored.
- Async reset mid-right-word:
  - Stimulus: rst pulsed low.
  - Response: outputs go to 0 immediately; the next valid pair 0x4444/0x7398 is received correctly after ws realignment.
- I2SI_PHILIPS_DELAY_EN build:
  - Stimulus: a one-bit-delayed frame carrying L=0xFFDD/R=0x1111.
  - Response: i2si_lft=0xFFDD, i2si_rgt=0x1111.

Source files
------------

// File: rtl/i2si_pkg.sv
// Shared constants for the I2S input deserializer: default widths and channel encoding.
package i2si_pkg;

    localparam int DW_DEFAULT          = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2si_sync.sv
// N-flop synchronizer for a single asynchronous input bit, cleared by the async active-low reset.
module i2si_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[N-2:0], d};
        end
    end

    assign q = ff_q[N-1];

endmodule

// File: rtl/i2si_deserializer.sv
// I2S receiver: samples sck/ws/sd in the clk domain and emits stereo pairs with a one-clk strobe.
// Define I2SI_PHILIPS_DELAY_EN for Philips framing (MSB one bit period after the ws change).
module i2si_deserializer
    import i2si_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2si_sck,
    input  logic          i2si_ws,
    input  logic          i2si_sd,
    input  logic          rf_i2si_en,
    output logic [DW-1:0] i2si_lft,
    output logic [DW-1:0] i2si_rgt,
    output logic          i2si_xfc
);

    localparam int             CW       = $clog2(DW);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0]  CNT_PEN  = CW'(DW - 2);

    logic          sck_s, ws_s, sd_s;
    logic          sck_d_q;
    logic          sck_rise, ws_chg, shift_bit, word_done;
    logic [DW-1:0] shift_q, word_next;
    logic [CW-1:0] cnt_q;
    logic          aligned_q, prev_ws_q, rgt_done_q;
    logic [DW-1:0] left_stage_q, lft_q, rgt_q;
    logic          xfc_q;

    i2si_sync #(.N(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst(rst), .d(i2si_sck), .q(sck_s));
    i2si_sync #(.N(SYNC_STAGES)) u_sync_ws  (.clk(clk), .rst(rst), .d(i2si_ws),  .q(ws_s));
    i2si_sync #(.N(SYNC_STAGES)) u_sync_sd  (.clk(clk), .rst(rst), .d(i2si_sd),  .q(sd_s));

    assign sck_rise  = sck_s & ~sck_d_q;
    assign ws_chg    = sck_rise & (ws_s != prev_ws_q);
    assign word_next = {shift_q[DW-2:0], sd_s};

`ifdef I2SI_PHILIPS_DELAY_EN
    // The ws-change edge carries the previous word's LSB; the MSB arrives on the next edge.
    logic wait_msb_q;
    logic load_bit;

    assign load_bit  = sck_rise & ~ws_chg & aligned_q & wait_msb_q;
    assign shift_bit = sck_rise & ~ws_chg & aligned_q & ~wait_msb_q & (cnt_q < CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_msb_q <= 1'b0;
        end else if (!rf_i2si_en) begin
            wait_msb_q <= 1'b0;
        end else if (ws_chg) begin
            wait_msb_q <= 1'b1;
        end else if (load_bit) begin
            wait_msb_q <= 1'b0;
        end
    end
`else
    assign shift_bit = sck_rise & ~ws_chg & aligned_q & (cnt_q < CNT_LAST);
`endif

    // The DW-th bit is the shift that leaves the counter at DW-1.
    assign word_done = rf_i2si_en & shift_bit & (cnt_q == CNT_PEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_d_q   <= 1'b0;
            prev_ws_q <= 1'b1;
        end else begin
            sck_d_q <= sck_s;
            if (sck_rise) begin
                prev_ws_q <= ws_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            aligned_q <= 1'b0;
        end else if (!rf_i2si_en) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            aligned_q <= 1'b0;
        end else if (ws_chg) begin
            aligned_q <= 1'b1;
            cnt_q     <= '0;
`ifdef I2SI_PHILIPS_DELAY_EN
            shift_q   <= '0;
        end else if (load_bit) begin
            cnt_q     <= '0;
            shift_q   <= {{(DW-1){1'b0}}, sd_s};
`else
            shift_q   <= {{(DW-1){1'b0}}, sd_s};
`endif
        end else if (shift_bit) begin
            shift_q <= word_next;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Left words wait in a staging register; a completed right word releases the pair next clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_stage_q <= '0;
            rgt_done_q   <= 1'b0;
            lft_q        <= '0;
            rgt_q        <= '0;
            xfc_q        <= 1'b0;
        end else begin
            if (word_done && ws_s == CH_LEFT) begin
                left_stage_q <= word_next;
            end
            rgt_done_q <= word_done & (ws_s == CH_RIGHT);
            xfc_q      <= rgt_done_q & rf_i2si_en;
            if (rgt_done_q && rf_i2si_en) begin
                lft_q <= left_stage_q;
                rgt_q <= shift_q;
            end
        end
    end

    assign i2si_lft = lft_q;
    assign i2si_rgt = rgt_q;
    assign i2si_xfc = xfc_q;

endmodule

// File: tb/tb_i2si_deserializer.sv
// Directed + randomized bench for i2si_deserializer with a word-level reference model and scoreboard.
module tb_i2si_deserializer;
    import i2si_pkg::*;

    localparam int W  = 16;
    localparam int NS = 2;

    logic          clk = 1'b0;
    logic          rst, sck, ws, sd, en;
    logic [W-1:0]  lft, rgt;
    logic          xfc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    i2si_deserializer #(.DW(W), .SYNC_STAGES(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .i2si_sck   (sck),
        .i2si_ws    (ws),
        .i2si_sd    (sd),
        .rf_i2si_en (en),
        .i2si_lft   (lft),
        .i2si_rgt   (rgt),
        .i2si_xfc   (xfc)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model state (word level: bits collected per ws phase)
    bit            m_prev_ws = 1'b1;
    bit            m_aligned = 1'b0;
    bit            m_bits[$];
    logic [W-1:0]  m_stage   = '0;
    logic [W-1:0]  cur_l     = '0;
    logic [W-1:0]  cur_r     = '0;

    // Scoreboard: expected {left,right} pairs and the cycle of the completing sck rise
    logic [2*W-1:0] exp_q[$];
    int             exp_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_ws = 1'b1;
        m_aligned = 1'b0;
        m_bits.delete();
        m_stage = '0;
        cur_l   = '0;
        cur_r   = '0;
    endtask

    task automatic model_complete(input bit w);
        logic [W-1:0] word = '0;
        foreach (m_bits[i]) word = {word[W-2:0], m_bits[i]};
        if (w == CH_LEFT) begin
            m_stage = word;
        end else begin
            exp_q.push_back({m_stage, word});
            exp_cyc_q.push_back(cyc);
        end
    endtask

    task automatic model_rise(input bit w, input bit d);
        if (!en) begin
            m_aligned = 1'b0;
            m_bits.delete();
        end else if (w != m_prev_ws) begin
            m_aligned = 1'b1;
            m_bits.delete();
`ifndef I2SI_PHILIPS_DELAY_EN
            m_bits.push_back(d);
`endif
        end else if (m_aligned && m_bits.size() < W) begin
            m_bits.push_back(d);
            if (m_bits.size() == W) model_complete(w);
        end
        m_prev_ws = w;
    endtask

    // Driver tasks: ws/sd change with sck falling, each sck phase 4..7 clk long
    task automatic half_period();
        repeat ($urandom_range(4, 7)) @(negedge clk);
    endtask

    task automatic send_bit(input bit w, input bit d);
        ws = w;
        sd = d;
        half_period();
        sck = 1'b1;
        model_rise(w, d);
        half_period();
        sck = 1'b0;
    endtask

    task automatic send_phase(input bit w, input logic [W-1:0] word, input int nbits,
                              input int en_on_at);
`ifdef I2SI_PHILIPS_DELAY_EN
        send_bit(w, 1'($urandom));
`endif
        for (int i = 0; i < nbits; i++) begin
            if (i == en_on_at) en = 1'b1;
            send_bit(w, (i < W) ? word[W-1-i] : 1'($urandom));
        end
    endtask

    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        send_phase(CH_LEFT, l, W, -1);
        send_phase(CH_RIGHT, r, W, -1);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_lft"}, 32'(lft), 32'(cur_l));
        chk({tag, "_rgt"}, 32'(rgt), 32'(cur_r));
    endtask

    // Monitor: every xfc pulse must match the oldest expected pair, with fixed latency
    always @(negedge clk) begin
        if (rst === 1'b1 && xfc === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("xfc_unexpected", 32'(xfc), 32'd0);
            end else begin
                logic [2*W-1:0] e;
                int             c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                chk("xfc_lft", 32'(lft), 32'(e[2*W-1:W]));
                chk("xfc_rgt", 32'(rgt), 32'(e[W-1:0]));
                chk("xfc_latency", 32'(cyc - c), 32'(NS + 2));
                cur_l = e[2*W-1:W];
                cur_r = e[W-1:0];
            end
        end
    end

    initial begin
        logic [W-1:0] l, r;
        int           nl, nr;

        // Reset and enable
        rst = 1'b0; sck = 1'b0; ws = 1'b1; sd = 1'b0; en = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        chk("rst_lft", 32'(lft), 32'd0);
        chk("rst_rgt", 32'(rgt), 32'd0);
        chk("rst_xfc", 32'(xfc), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_out("post_rst");
        chk("post_rst_xfc", 32'(xfc), 32'd0);

        send_pair(16'hAAAA, 16'h0000);
        settle();
        check_out("first_pair");

        // Back-to-back frames
        send_pair(16'hFF00, 16'h1478);
        send_pair(16'hA3B9, 16'hCDD7);
        settle();
        check_out("frames");

        // Disabled frame, then re-enable mid-left and a short right phase
        en = 1'b0;
        send_pair(16'h1234, 16'h5678);
        settle();
        check_out("disabled_hold");
        send_phase(CH_LEFT, 16'h9ABC, W, 7);
        send_phase(CH_RIGHT, 16'h0F0F, 8, -1);
        settle();
        check_out("reenable_hold");
        send_pair(16'h3C5A, 16'hE621);
        settle();
        check_out("reenable_pair");

        // Short left word, long right word
        send_phase(CH_LEFT, 16'h7777, 10, -1);
        send_phase(CH_RIGHT, 16'hBABA, 20, -1);
        settle();
        chk("long_rgt", 32'(rgt), 32'h0000BABA);
        check_out("short_long");

        // Async reset in the middle of a right word
        send_phase(CH_LEFT, 16'h5A5A, W, -1);
        send_phase(CH_RIGHT, 16'hC3C3, 6, -1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_lft", 32'(lft), 32'd0);
        chk("midrst_rgt", 32'(rgt), 32'd0);
        chk("midrst_xfc", 32'(xfc), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_phase(CH_RIGHT, 16'hC3C3, 10, -1);
        send_pair(16'h4444, 16'h7398);
        settle();
        chk("realign_lft", 32'(lft), 32'h00004444);
        chk("realign_rgt", 32'(rgt), 32'h00007398);

`ifdef I2SI_PHILIPS_DELAY_EN
        send_pair(16'hFFDD, 16'h1111);
        settle();
        chk("philips_lft", 32'(lft), 32'h0000FFDD);
        chk("philips_rgt", 32'(rgt), 32'h00001111);
`endif

        // Randomized frames, some with truncated left or extended right phases
        for (int k = 0; k < 24; k++) begin
            l  = 16'($urandom);
            r  = 16'($urandom);
            nl = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 15) : W;
            nr = W + $urandom_range(0, 3);
            send_phase(CH_LEFT, l, nl, -1);
            send_phase(CH_RIGHT, r, nr, -1);
        end
        settle();
        check_out("random_end");

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
